flash_burst_reader: RTL

Read-sequencing stage for the board's parallel StrataFlash in x8 mode. Accepts a start address and byte count, drives the flash address and strobes, and starts the flash access timer for each byte. It waits for the timer's done flag, latches the data bus, and streams the bytes to the downstream consumer, typically the score-table loader. The block sits directly upstream of the flash access timer and drives its start/done handshake.

---
 rtl/flash_pkg.sv | 33 +++
 rtl/flash_watchdog.sv | 43 ++++
 rtl/flash_burst_reader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// -----------------------------------------------------------------------------
// flash_pkg
// Shared definitions for the StrataFlash read path:
//   - FLASH_ADDR_W    : default flash byte-address width (x8 mode)
//   - flash_state_e   : burst reader FSM encoding
//   - flash_strobes_t : grouped active-low flash strobes (CE0, OE, WE)
//   - STROBE_IDLE     : all strobes deasserted
//   - STROBE_READ     : chip enabled, output enabled, write held off
// -----------------------------------------------------------------------------
package flash_pkg;

    localparam int unsigned FLASH_ADDR_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT,
        LATCH,
        DONE,
        ERR
    } flash_state_e;

    typedef struct packed {
        logic ce0;
        logic oe;
        logic we;
    } flash_strobes_t;

    localparam flash_strobes_t STROBE_IDLE = '{ce0: 1'b1, oe: 1'b1, we: 1'b1};
    localparam flash_strobes_t STROBE_READ = '{ce0: 1'b0, oe: 1'b0, we: 1'b1};

endpackage

// File: rtl/flash_watchdog.sv
// -----------------------------------------------------------------------------
// flash_watchdog
// Counts cycles spent waiting on the flash access timer and flags when the
// wait has reached TIMEOUT_CYC - 1 cycles without being cleared.
//
// Parameters:
//   TIMEOUT_CYC : watchdog limit in clocks
// Ports:
//   clk     in  : system clock, rising edge
//   rst_n   in  : asynchronous active-low reset
//   clr     in  : restart the count from zero (one per access)
//   en      in  : count this cycle (high while waiting)
//   expired out : count has reached TIMEOUT_CYC - 1
// -----------------------------------------------------------------------------
module flash_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned    CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at the limit so a stalled FSM cannot wrap the count back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/flash_burst_reader.sv
// -----------------------------------------------------------------------------
// flash_burst_reader
// Read sequencer for the parallel StrataFlash in x8 mode. A request supplies a
// start address and byte count; for each byte the block drives the address,
// enables the flash outputs, kicks the external access timer, waits for its
// done level, latches the data bus and emits the byte downstream.
//
// Optional feature (compile-time macro FLASH_READER_TIMEOUT_EN):
//   defined     : a watchdog (flash_watchdog) bounds every timer wait; on
//                 expiry the burst aborts through ERR and err is set (sticky
//                 until the next accepted request).
//   not defined : waits are unbounded, ERR is never entered, err is tied 0.
//
// Parameters:
//   ADDR_W      : flash byte-address width
//   LEN_W       : burst length width (max burst 2^LEN_W - 1 bytes)
//   TIMEOUT_CYC : watchdog limit in clocks per timer wait
// Ports:
//   CLK_50MHZ         in  : system clock, rising edge
//   RST_N             in  : asynchronous active-low reset
//   req               in  : start burst (sampled only when idle)
//   req_addr          in  : first byte address
//   req_len           in  : byte count; 0 completes immediately, no access
//   busy              out : burst in progress
//   rd_valid          out : one-cycle pulse per byte
//   rd_data           out : byte, held until the next rd_valid
//   burst_done        out : one-cycle pulse at burst end (not on abort)
//   err               out : sticky timeout flag
//   flash_timer_start out : one-cycle start pulse to the access timer
//   flash_timer_done  in  : access-complete level from the timer
//   SF_A              out : flash address
//   SF_D              in  : flash data bus
//   SF_CE0/SF_OE/SF_WE out: active-low flash strobes (WE never asserted)
//   SF_BYTE           out : tied 0 for x8 mode
// -----------------------------------------------------------------------------
module flash_burst_reader
    import flash_pkg::*;
#(
    parameter int unsigned ADDR_W      = FLASH_ADDR_W,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              CLK_50MHZ,
    input  logic              RST_N,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              busy,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    output logic              burst_done,
    output logic              err,
    output logic              flash_timer_start,
    input  logic              flash_timer_done,
    output logic [ADDR_W-1:0] SF_A,
    input  logic [7:0]        SF_D,
    output logic              SF_CE0,
    output logic              SF_OE,
    output logic              SF_WE,
    output logic              SF_BYTE
);

    flash_state_e   state_q;
    flash_state_e   state_d;
    flash_strobes_t strb;

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              first_wait_q;
    logic              accept;
    logic              zero_req;
    logic              wd_expired;

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d           = state_q;
        busy              = 1'b1;
        strb              = STROBE_READ;
        flash_timer_start = 1'b0;
        accept            = 1'b0;
        zero_req          = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                strb = STROBE_IDLE;
                if (req) begin
                    if (req_len != '0) begin
                        accept  = 1'b1;
                        state_d = SETUP;
                    end else begin
                        zero_req = 1'b1;
                    end
                end
            end

            SETUP: begin
                state_d = START;
            end

            START: begin
                flash_timer_start = 1'b1;
                state_d           = WAIT;
            end

            // The timer may still show done from the previous byte during
            // the first wait cycle, so that cycle never completes the wait.
            WAIT: begin
                if (!first_wait_q && flash_timer_done) begin
                    state_d = LATCH;
                end else if (wd_expired) begin
                    state_d = ERR;
                end
            end

            LATCH: begin
                state_d = (cnt_q == LEN_W'(1)) ? DONE : SETUP;
            end

            DONE: begin
                strb    = STROBE_IDLE;
                state_d = IDLE;
            end

            ERR: begin
                strb    = STROBE_IDLE;
                state_d = IDLE;
            end

            default: begin
                busy    = 1'b0;
                strb    = STROBE_IDLE;
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Address/count tracking and registered read outputs
    // ---------------------------------------------------------------------
    // addr_q doubles as SF_A: it is loaded on accept and advanced in LATCH,
    // so the next address is already on the bus from the following SETUP.
    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            addr_q       <= '0;
            cnt_q        <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            burst_done   <= 1'b0;
            first_wait_q <= 1'b0;
        end else begin
            rd_valid     <= (state_q == LATCH);
            burst_done   <= (state_q == DONE) || zero_req;
            first_wait_q <= (state_q == START);

            if (accept) begin
                addr_q <= req_addr;
                cnt_q  <= req_len;
            end else if (state_q == LATCH) begin
                rd_data <= SF_D;
                addr_q  <= addr_q + ADDR_W'(1);
                cnt_q   <= cnt_q - LEN_W'(1);
            end
        end
    end

`ifdef FLASH_READER_TIMEOUT_EN
    logic wd_clr;
    logic wd_en;
    logic err_q;

    assign wd_clr = (state_q == START);
    assign wd_en  = (state_q == WAIT);

    flash_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (CLK_50MHZ),
        .rst_n   (RST_N),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state_q == ERR) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

    assign SF_A    = addr_q;
    assign SF_CE0  = strb.ce0;
    assign SF_OE   = strb.oe;
    assign SF_WE   = strb.we;
    assign SF_BYTE = 1'b0;

endmodule
